// File: rtl/pl_reg_mw_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pl_reg_mw_hs_pkg
// Brief    : Shared M/W pipeline types: writeback-source encodings and the
//            stored entry record.
// Revision : 1.0 - initial release
// ============================================================================
package pl_reg_mw_hs_pkg;

    // Entry fields are sized for the widest supported configuration; narrower
    // instances zero-extend into them.
    localparam int XLEN_MAX = 64;
    localparam int AW_MAX   = 8;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_AUI = 2'b11
    } result_sel_e;

    typedef struct packed {
        logic                regwr;
        logic [AW_MAX-1:0]   wr_addr;
        logic [XLEN_MAX-1:0] wb_data;
    } mw_entry_t;

    localparam int ENTRY_W = $bits(mw_entry_t);

endpackage
`default_nettype wire

// File: rtl/skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : skid_buf
// Brief    : Two-entry FIFO-ordered buffer (main + skid) with valid/ready on
//            both sides; input ready depends only on registered state.
// Revision : 1.0 - initial release
// ============================================================================
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic         r_main_valid_q, w_main_valid_d;
    logic [W-1:0] r_main_q,       w_main_d;
    logic         r_skid_valid_q, w_skid_valid_d;
    logic [W-1:0] r_skid_q,       w_skid_d;
    logic         w_accept;
    logic         w_drain;

    // Skid full implies main full, so skid occupancy alone decides readiness.
    assign o_ready  = ~r_skid_valid_q;
    assign w_accept = i_valid & o_ready & ~i_flush;
    assign w_drain  = r_main_valid_q & i_ready;

    always_comb begin
        w_main_valid_d = r_main_valid_q;
        w_main_d       = r_main_q;
        w_skid_valid_d = r_skid_valid_q;
        w_skid_d       = r_skid_q;

        if (w_drain) begin
            if (r_skid_valid_q) begin
                w_main_d       = r_skid_q;
                w_skid_valid_d = 1'b0;
            end else if (w_accept) begin
                w_main_d       = i_data;
            end else begin
                w_main_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            if (r_main_valid_q) begin
                w_skid_d       = i_data;
                w_skid_valid_d = 1'b1;
            end else begin
                w_main_d       = i_data;
                w_main_valid_d = 1'b1;
            end
        end

        if (i_flush) begin
            w_main_valid_d = 1'b0;
            w_skid_valid_d = 1'b0;
            w_main_d       = '0;
            w_skid_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid_q <= 1'b0;
            r_main_q       <= '0;
            r_skid_valid_q <= 1'b0;
            r_skid_q       <= '0;
        end else begin
            r_main_valid_q <= w_main_valid_d;
            r_main_q       <= w_main_d;
            r_skid_valid_q <= w_skid_valid_d;
            r_skid_q       <= w_skid_d;
        end
    end

    assign o_valid = r_main_valid_q;
    assign o_data  = r_main_q;
    assign o_count = 2'(r_main_valid_q) + 2'(r_skid_valid_q);

endmodule
`default_nettype wire

// File: rtl/pl_reg_mw_hs.sv
`default_nettype none
// ============================================================================
// Module   : pl_reg_mw_hs
// Brief    : M->W pipeline register with valid/ready handshake, writeback
//            source mux, x0-write suppression and a one-entry skid.
// Revision : 1.0 - initial release
// ============================================================================
module pl_reg_mw_hs
    import pl_reg_mw_hs_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            m_valid,
    output logic            m_ready,
    input  logic            m_regwr,
    input  logic [1:0]      m_result_sel,
    input  logic [AW-1:0]   m_wr_addr,
    input  logic [XLEN-1:0] m_alu_result,
    input  logic [XLEN-1:0] m_read_data,
    input  logic [XLEN-1:0] m_pc_4,
    input  logic [XLEN-1:0] m_aui_lui_result,
    output logic            w_valid,
    input  logic            w_ready,
    output logic            w_regwr,
    output logic [AW-1:0]   w_wr_addr,
    output logic [XLEN-1:0] w_wb_data,
    output logic [1:0]      occupancy
);

    logic [XLEN-1:0] w_wb_mux;
    mw_entry_t       w_in_entry;
    mw_entry_t       w_out_entry;
    logic            w_out_valid;
    logic            w_unused_hi;

    always_comb begin
        w_wb_mux = m_alu_result;
        case (result_sel_e'(m_result_sel))
            RES_ALU: w_wb_mux = m_alu_result;
            RES_MEM: w_wb_mux = m_read_data;
            RES_PC4: w_wb_mux = m_pc_4;
            RES_AUI: w_wb_mux = m_aui_lui_result;
            default: w_wb_mux = m_alu_result;
        endcase
    end

    // Writes to x0 are architecturally discarded, so drop the enable here.
    always_comb begin
        w_in_entry         = '0;
        w_in_entry.regwr   = m_regwr & (m_wr_addr != '0);
        w_in_entry.wr_addr = AW_MAX'(m_wr_addr);
        w_in_entry.wb_data = XLEN_MAX'(w_wb_mux);
    end

    skid_buf #(
        .W (ENTRY_W)
    ) u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_valid (m_valid),
        .o_ready (m_ready),
        .i_data  (w_in_entry),
        .o_valid (w_out_valid),
        .i_ready (w_ready),
        .o_data  (w_out_entry),
        .o_count (occupancy)
    );

    assign w_valid     = w_out_valid;
    assign w_regwr     = w_out_valid & w_out_entry.regwr;
    assign w_wr_addr   = w_out_entry.wr_addr[AW-1:0];
    assign w_wb_data   = w_out_entry.wb_data[XLEN-1:0];
    // Zero-extended upper field bits are never read back.
    assign w_unused_hi = ^{w_out_entry.wr_addr, w_out_entry.wb_data};

endmodule
`default_nettype wire

// File: tb/tb_pl_reg_mw_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pl_reg_mw_hs
// Brief    : Directed self-checking bench for pl_reg_mw_hs (XLEN=32 and 64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pl_reg_mw_hs;

    logic        clk = 1'b0;
    logic        rst, flush, m_valid, m_regwr, w_ready;
    logic [1:0]  m_result_sel;
    logic [4:0]  m_wr_addr;
    logic [63:0] m_alu_result, m_read_data, m_pc_4, m_aui_lui_result;

    logic        m_ready, w_valid, w_regwr;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wb_data;
    logic [1:0]  occupancy;

    logic        m_ready64, w_valid64, w_regwr64;
    logic [4:0]  w_wr_addr64;
    logic [63:0] w_wb_data64;
    logic [1:0]  occupancy64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pl_reg_mw_hs #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready), .m_regwr(m_regwr),
        .m_result_sel(m_result_sel), .m_wr_addr(m_wr_addr),
        .m_alu_result(m_alu_result[31:0]), .m_read_data(m_read_data[31:0]),
        .m_pc_4(m_pc_4[31:0]), .m_aui_lui_result(m_aui_lui_result[31:0]),
        .w_valid(w_valid), .w_ready(w_ready), .w_regwr(w_regwr),
        .w_wr_addr(w_wr_addr), .w_wb_data(w_wb_data), .occupancy(occupancy)
    );

    pl_reg_mw_hs #(.XLEN(64), .AW(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready64), .m_regwr(m_regwr),
        .m_result_sel(m_result_sel), .m_wr_addr(m_wr_addr),
        .m_alu_result(m_alu_result), .m_read_data(m_read_data),
        .m_pc_4(m_pc_4), .m_aui_lui_result(m_aui_lui_result),
        .w_valid(w_valid64), .w_ready(w_ready), .w_regwr(w_regwr64),
        .w_wr_addr(w_wr_addr64), .w_wb_data(w_wb_data64), .occupancy(occupancy64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Selected source carries val; the other sources carry distinct decoys.
    task automatic put(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [4:0] addr, input logic [63:0] val);
        m_valid          = v;
        m_regwr          = rw;
        m_result_sel     = sel;
        m_wr_addr        = addr;
        m_alu_result     = 64'h1111_1111_A1A1_A1A1;
        m_read_data      = 64'h2222_2222_B2B2_B2B2;
        m_pc_4           = 64'h3333_3333_C3C3_C3C3;
        m_aui_lui_result = 64'h4444_4444_D4D4_D4D4;
        case (sel)
            2'b00: m_alu_result     = val;
            2'b01: m_read_data      = val;
            2'b10: m_pc_4           = val;
            default: m_aui_lui_result = val;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; w_ready = 1'b0;
        put(1'b0, 1'b0, 2'b00, 5'd0, 64'd0);
        step(); step();
        rst = 1'b0;
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        n_checks++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid: got %b expected 0", w_valid); end
        n_checks++; if (w_regwr !== 1'b0) begin n_fail++; $display("FAIL reset_regwr: got %b expected 0", w_regwr); end
        n_checks++; if (w_wr_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", w_wr_addr); end
        n_checks++; if (w_wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", w_wb_data); end
        n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mready: got %b expected 1", m_ready); end
    endtask

    task automatic test_basic();
        w_ready = 1'b1;
        put(1'b1, 1'b1, 2'b00, 5'd5, 64'h1234);
        step();
        put(1'b0, 1'b0, 2'b00, 5'd0, 64'd0);
        n_checks++; if (w_valid !== 1'b1) begin n_fail++; $display("FAIL basic_wvalid: got %b expected 1", w_valid); end
        n_checks++; if (w_wb_data !== 32'h0000_1234) begin n_fail++; $display("FAIL basic_data: got %h expected 00001234", w_wb_data); end
        n_checks++; if (w_regwr !== 1'b1) begin n_fail++; $display("FAIL basic_regwr: got %b expected 1", w_regwr); end
        n_checks++; if (w_wr_addr !== 5'd5) begin n_fail++; $display("FAIL basic_addr: got %0d expected 5", w_wr_addr); end
        n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL basic_occ: got %0d expected 1", occupancy); end
        step();
        n_checks++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain_wvalid: got %b expected 0", w_valid); end
        n_checks++; if (w_regwr !== 1'b0) begin n_fail++; $display("FAIL basic_drain_regwr: got %b expected 0", w_regwr); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL basic_drain_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_x0();
        w_ready = 1'b0;
        put(1'b1, 1'b1, 2'b01, 5'd0, 64'hDEAD_BEEF);
        step();
        put(1'b0, 1'b0, 2'b00, 5'd0, 64'd0);
        n_checks++; if (w_valid !== 1'b1) begin n_fail++; $display("FAIL x0_wvalid: got %b expected 1", w_valid); end
        n_checks++; if (w_regwr !== 1'b0) begin n_fail++; $display("FAIL x0_regwr: got %b expected 0", w_regwr); end
        n_checks++; if (w_wb_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL x0_data: got %h expected deadbeef", w_wb_data); end
        w_ready = 1'b1;
        step();
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL x0_drain_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_backpressure();
        w_ready = 1'b0;
        put(1'b1, 1'b1, 2'b00, 5'd1, 64'hAAAA_0001);
        step();
        n_checks++; if (m_ready !== 1'b1 || occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_after_a: got ready=%b occ=%0d expected ready=1 occ=1", m_ready, occupancy); end
        put(1'b1, 1'b1, 2'b00, 5'd2, 64'hBBBB_0002);
        step();
        n_checks++; if (m_ready !== 1'b0 || occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_after_b: got ready=%b occ=%0d expected ready=0 occ=2", m_ready, occupancy); end
        put(1'b1, 1'b1, 2'b00, 5'd3, 64'hCCCC_0003);
        step();
        n_checks++; if (occupancy !== 2'd2 || m_ready !== 1'b0) begin n_fail++; $display("FAIL bp_c_waits: got occ=%0d ready=%b expected occ=2 ready=0", occupancy, m_ready); end
        n_checks++; if (w_wb_data !== 32'hAAAA_0001 || w_wr_addr !== 5'd1) begin n_fail++; $display("FAIL bp_stable_a: got %h/%0d expected aaaa0001/1", w_wb_data, w_wr_addr); end
        w_ready = 1'b1;
        step();
        n_checks++; if (w_wb_data !== 32'hBBBB_0002 || w_wr_addr !== 5'd2) begin n_fail++; $display("FAIL bp_out_b: got %h/%0d expected bbbb0002/2", w_wb_data, w_wr_addr); end
        n_checks++; if (occupancy !== 2'd1 || m_ready !== 1'b1) begin n_fail++; $display("FAIL bp_occ_after_drain: got occ=%0d ready=%b expected occ=1 ready=1", occupancy, m_ready); end
        step();
        put(1'b0, 1'b0, 2'b00, 5'd0, 64'd0);
        n_checks++; if (w_wb_data !== 32'hCCCC_0003 || w_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_c: got %h valid=%b expected cccc0003 valid=1", w_wb_data, w_valid); end
        n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_occ_c: got %0d expected 1", occupancy); end
        step();
        n_checks++; if (occupancy !== 2'd0 || w_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got occ=%0d valid=%b expected 0/0", occupancy, w_valid); end
    endtask

    task automatic fill_two();
        w_ready = 1'b0;
        put(1'b1, 1'b1, 2'b00, 5'd7, 64'h0000_7777);
        step();
        put(1'b1, 1'b1, 2'b00, 5'd8, 64'h0000_8888);
        step();
    endtask

    task automatic test_flush();
        fill_two();
        n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_prefill: got %0d expected 2", occupancy); end
        flush = 1'b1;
        put(1'b1, 1'b1, 2'b00, 5'd9, 64'h0000_9999);
        step();
        flush = 1'b0;
        put(1'b0, 1'b0, 2'b00, 5'd0, 64'd0);
        n_checks++; if (occupancy !== 2'd0 || w_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got occ=%0d valid=%b expected 0/0", occupancy, w_valid); end
        n_checks++; if (w_regwr !== 1'b0 || m_ready !== 1'b1) begin n_fail++; $display("FAIL flush_regwr_ready: got regwr=%b ready=%b expected 0/1", w_regwr, m_ready); end
        w_ready = 1'b1;
        step();
        n_checks++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got valid=%b expected 0", w_valid); end
    endtask

    task automatic test_reset_mid_stall();
        fill_two();
        rst = 1'b1; flush = 1'b1; w_ready = 1'b1;
        put(1'b1, 1'b1, 2'b00, 5'd10, 64'h0000_AAAA);
        step();
        rst = 1'b0; flush = 1'b0;
        put(1'b0, 1'b0, 2'b00, 5'd0, 64'd0);
        n_checks++; if (occupancy !== 2'd0 || w_valid !== 1'b0 || w_regwr !== 1'b0) begin n_fail++; $display("FAIL rst_stall_state: got occ=%0d valid=%b regwr=%b expected 0/0/0", occupancy, w_valid, w_regwr); end
        n_checks++; if (w_wr_addr !== 5'd0 || w_wb_data !== 32'd0) begin n_fail++; $display("FAIL rst_stall_data: got %0d/%h expected 0/0", w_wr_addr, w_wb_data); end
        n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL rst_stall_mready: got %b expected 1", m_ready); end
        put(1'b1, 1'b1, 2'b00, 5'd11, 64'h0000_D00D);
        step();
        put(1'b0, 1'b0, 2'b00, 5'd0, 64'd0);
        n_checks++; if (w_valid !== 1'b1 || w_wb_data !== 32'h0000_D00D || w_wr_addr !== 5'd11) begin n_fail++; $display("FAIL rst_stall_latency: got valid=%b %h/%0d expected 1 0000d00d/11", w_valid, w_wb_data, w_wr_addr); end
        step();
    endtask

    task automatic test_mux_sweep();
        w_ready = 1'b1;
        put(1'b1, 1'b1, 2'b10, 5'd12, 64'h104);
        step();
        n_checks++; if (w_wb_data !== 32'h0000_0104) begin n_fail++; $display("FAIL mux_pc4_32: got %h expected 00000104", w_wb_data); end
        n_checks++; if (w_wb_data64 !== 64'h0000_0000_0000_0104) begin n_fail++; $display("FAIL mux_pc4_64: got %h expected 0000000000000104", w_wb_data64); end
        put(1'b1, 1'b1, 2'b11, 5'd13, 64'h1234_5678_ABCD_E000);
        step();
        n_checks++; if (w_wb_data !== 32'hABCD_E000) begin n_fail++; $display("FAIL mux_aui_32: got %h expected abcde000", w_wb_data); end
        n_checks++; if (w_wb_data64 !== 64'h1234_5678_ABCD_E000) begin n_fail++; $display("FAIL mux_aui_64: got %h expected 12345678abcde000", w_wb_data64); end
        n_checks++; if (w_valid64 !== 1'b1 || w_regwr64 !== 1'b1 || w_wr_addr64 !== 5'd13) begin n_fail++; $display("FAIL mux_ctrl_64: got valid=%b regwr=%b addr=%0d expected 1/1/13", w_valid64, w_regwr64, w_wr_addr64); end
        n_checks++; if (occupancy64 !== 2'd1 || m_ready64 !== 1'b1) begin n_fail++; $display("FAIL mux_occ_64: got occ=%0d ready=%b expected 1/1", occupancy64, m_ready64); end
        put(1'b1, 1'b0, 2'b01, 5'd14, 64'hFEDC_BA98_7654_3210);
        step();
        put(1'b0, 1'b0, 2'b00, 5'd0, 64'd0);
        n_checks++; if (w_wb_data64 !== 64'hFEDC_BA98_7654_3210 || w_regwr64 !== 1'b0) begin n_fail++; $display("FAIL mux_mem_64: got %h regwr=%b expected fedcba9876543210 regwr=0", w_wb_data64, w_regwr64); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_x0();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_mux_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pl_reg_mw_hs.md
PL_REG_MW_HS -- requirements
Module: pl_reg_mw_hs

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the datapath word width.
REQ-002 The block SHALL have parameter AW, default 5, meaning the register-file address width.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flush  input  1  discards all held entries and the current input.
REQ-007 m_valid  input  1  the M-stage bundle is valid.
REQ-008 m_ready  output  1  the block accepts a bundle this cycle.
REQ-009 m_regwr  input  1  register-write enable.
REQ-010 m_result_sel  input  2  writeback source: 00 ALU, 01 load data, 10 PC+4, 11 AUIPC/LUI.
REQ-011 m_wr_addr  input  AW  destination register.
REQ-012 m_alu_result  input  XLEN  ALU result.
REQ-013 m_read_data  input  XLEN  load data.
REQ-014 m_pc_4  input  XLEN  PC+4 (link value).
REQ-015 m_aui_lui_result  input  XLEN  AUIPC/LUI result.
REQ-016 w_valid  output  1  the W-stage bundle is valid.
REQ-017 w_ready  input  1  the W stage consumes the bundle this cycle.
REQ-018 w_regwr  output  1  effective register-write enable.
REQ-019 w_wr_addr  output  AW  destination register.
REQ-020 w_wb_data  output  XLEN  selected writeback value.
REQ-021 occupancy  output  2  number of held entries, 0..2.

Function
REQ-022 An entry SHALL be accepted at a rising edge when m_valid=1, m_ready=1 and flush=0.
REQ-023 Before storage, the writeback value SHALL be muxed by m_result_sel; only {regwr, wr_addr, wb_data} SHALL be stored per entry.
REQ-024 Stored regwr SHALL be m_regwr AND (m_wr_addr != 0), so x0 writes are suppressed.
REQ-025 Storage SHALL be a main register (driving w_*) plus one skid register, kept in FIFO order.
REQ-026 An entry accepted into an empty block SHALL appear on w_* with w_valid=1 in the next cycle (1-cycle latency).
REQ-027 m_ready SHALL equal (occupancy < 2) and SHALL depend only on registered state, with no combinational path from w_ready.
REQ-028 A drain SHALL occur when w_valid=1 and w_ready=1; on a drain, main SHALL load skid if skid is full, else the incoming entry if one is accepted, else main SHALL become empty.
REQ-029 An accept with main full and no drain SHALL load skid.
REQ-030 A simultaneous accept and drain SHALL leave occupancy unchanged.
REQ-031 With occupancy=2, a drain SHALL leave occupancy=1, and m_ready SHALL be 1 in the following cycle.
REQ-032 w_regwr, w_wr_addr and w_wb_data SHALL hold stable while w_valid=1 and w_ready=0.
REQ-033 flush=1 SHALL empty both registers at the edge (occupancy becomes 0, w_valid becomes 0), drop any input that cycle, and override simultaneous accept or drain.
REQ-034 When w_valid=0, w_regwr SHALL be 0.

Reset
REQ-035 On rst=1 at a rising edge, occupancy SHALL be 0 and w_valid, w_regwr, w_wr_addr and w_wb_data SHALL all be 0; m_ready SHALL be 1 in the next cycle.
REQ-036 rst SHALL take priority over flush and over any handshake, including mid-stall with occupancy=2.

Structure
REQ-037 The result_sel encodings (RES_ALU=00, RES_MEM=01, RES_PC4=10, RES_AUI=11) and the entry-record typedef SHALL live in the shared pipeline package.
REQ-038 The storage SHALL be one sub-module, skid_buf, parametrised by entry width; the writeback mux and x0 suppression SHALL stay in pl_reg_mw_hs.

Verification
REQ-039 Basic: accept {regwr=1, addr=5, sel=00, alu=0x1234} with w_ready=1 -> the next cycle shows w_valid=1, w_wb_data=0x00001234, w_regwr=1, occupancy=1.
REQ-040 Backpressure: w_ready=0, three back-to-back valid inputs A, B, C -> A and B are accepted, m_ready=0 while C waits; then w_ready=1 -> output order A, B, C with none lost or duplicated.
REQ-041 x0: regwr=1, addr=0, sel=01, read_data=0xDEADBEEF -> w_regwr=0, w_wb_data=0xDEADBEEF.
REQ-042 Flush: occupancy=2 with flush=1 and m_valid=1 -> the next cycle shows occupancy=0, w_valid=0, and the input is not delivered.
REQ-043 Reset mid-stall: occupancy=2, rst=1 -> all outputs are 0 and m_ready=1 the next cycle; a subsequent accept has 1-cycle latency.
REQ-044 Mux sweep with sel=10 and sel=11 (pc_4=0x104, aui=0xABCDE000) -> w_wb_data matches the selected source exactly; repeat with XLEN=64.
